multicycle_control: RTL and testbench

Multi-cycle successor to the single-cycle MIPS decoder: a Moore/Mealy FSM that sequences each instruction through fetch, decode, execute, memory and write-back states instead of decoding in one cycle. It sits beside the shared-memory datapath (single memory port, IR, A/B/ALUOut registers). It drives all datapath enables per state. It stalls on a memory ready handshake and counts retired instructions.

---
 rtl/multicycle_control.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS control FSM with memory handshake and retire counter.
// Optional macro MCTRL_ILLEGAL_TRAP_EN: unknown opcodes trap (sticky illegalOp) instead of acting as NOP.
`default_nettype none

module multicycle_control #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         i_opcode,
  input  logic [5:0]         i_funct,
  input  logic               i_memReady,
  output logic               o_pcWrite,
  output logic               o_pcWriteCond,
  output logic               o_branchNe,
  output logic [1:0]         o_pcSource,
  output logic               o_iorD,
  output logic               o_memRead,
  output logic               o_memWrite,
  output logic               o_irWrite,
  output logic [1:0]         o_regDst,
  output logic [1:0]         o_memToReg,
  output logic               o_regWrite,
  output logic               o_aluSrcA,
  output logic [1:0]         o_aluSrcB,
  output logic [ALUOP_W-1:0] o_aluOp,
  output logic [3:0]         o_state,
  output logic [CNT_W-1:0]   o_retired,
  output logic               o_illegalOp
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADDR = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_REXEC   = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_JUMP    = 4'd9,
    S_IEXEC   = 4'd10,
    S_IWB     = 4'd11,
    S_JR      = 4'd12,
    S_JAL     = 4'd13,
    S_TRAP    = 4'd14
  } state_t;

  localparam logic [5:0] c_OP_RTYPE = 6'd0;
  localparam logic [5:0] c_OP_J     = 6'd2;
  localparam logic [5:0] c_OP_JAL   = 6'd3;
  localparam logic [5:0] c_OP_BEQ   = 6'd4;
  localparam logic [5:0] c_OP_BNE   = 6'd5;
  localparam logic [5:0] c_OP_ADDI  = 6'd8;
  localparam logic [5:0] c_OP_ORI   = 6'd13;
  localparam logic [5:0] c_OP_LW    = 6'd35;
  localparam logic [5:0] c_OP_SW    = 6'd43;
  localparam logic [5:0] c_FN_JR    = 6'd8;

  localparam logic [1:0] c_ALU_ADD  = 2'd0;
  localparam logic [1:0] c_ALU_SUB  = 2'd1;
  localparam logic [1:0] c_ALU_FUNC = 2'd2;
  localparam logic [1:0] c_ALU_OR   = 2'd3;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_retired;

  logic       w_pcWrite, w_pcWriteCond, w_branchNe, w_iorD, w_memRead, w_memWrite;
  logic       w_irWrite, w_regWrite, w_aluSrcA;
  logic [1:0] w_pcSource, w_regDst, w_memToReg, w_aluSrcB, w_aluOp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      // TRAP never falls back to FETCH, but excluding it keeps the retire rule explicit.
      if (w_next == S_FETCH && r_state != S_FETCH && r_state != S_TRAP)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next        = r_state;
    w_pcWrite     = 1'b0;
    w_pcWriteCond = 1'b0;
    w_branchNe    = 1'b0;
    w_pcSource    = 2'b00;
    w_iorD        = 1'b0;
    w_memRead     = 1'b0;
    w_memWrite    = 1'b0;
    w_irWrite     = 1'b0;
    w_regDst      = 2'b00;
    w_memToReg    = 2'b00;
    w_regWrite    = 1'b0;
    w_aluSrcA     = 1'b0;
    w_aluSrcB     = 2'b00;
    w_aluOp       = c_ALU_ADD;
    // Gating by reset keeps every enable quiet while the asynchronous reset is held.
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          w_memRead = 1'b1;
          w_aluSrcB = 2'b01;
          if (i_memReady) begin
            w_irWrite = 1'b1;
            w_pcWrite = 1'b1;
            w_next    = S_DECODE;
          end
        end
        S_DECODE: begin
          w_aluSrcB = 2'b11;
          case (i_opcode)
            c_OP_RTYPE:        w_next = (i_funct == c_FN_JR) ? S_JR : S_REXEC;
            c_OP_LW, c_OP_SW:  w_next = S_MEMADDR;
            c_OP_BEQ, c_OP_BNE: w_next = S_BRANCH;
            c_OP_ADDI, c_OP_ORI: w_next = S_IEXEC;
            c_OP_J:            w_next = S_JUMP;
            c_OP_JAL:          w_next = S_JAL;
`ifdef MCTRL_ILLEGAL_TRAP_EN
            default:           w_next = S_TRAP;
`else
            default:           w_next = S_FETCH;
`endif
          endcase
        end
        S_MEMADDR: begin
          w_aluSrcA = 1'b1;
          w_aluSrcB = 2'b10;
          w_next    = (i_opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          w_memRead = 1'b1;
          w_iorD    = 1'b1;
          if (i_memReady) w_next = S_MEMWB;
        end
        S_MEMWB: begin
          w_regWrite = 1'b1;
          w_memToReg = 2'b01;
          w_next     = S_FETCH;
        end
        S_MEMWR: begin
          w_memWrite = 1'b1;
          w_iorD     = 1'b1;
          if (i_memReady) w_next = S_FETCH;
        end
        S_REXEC: begin
          w_aluSrcA = 1'b1;
          w_aluOp   = c_ALU_FUNC;
          w_next    = S_RWB;
        end
        S_RWB: begin
          w_regWrite = 1'b1;
          w_regDst   = 2'b01;
          w_next     = S_FETCH;
        end
        S_BRANCH: begin
          w_aluSrcA     = 1'b1;
          w_aluOp       = c_ALU_SUB;
          w_pcWriteCond = 1'b1;
          w_pcSource    = 2'b01;
          w_branchNe    = (i_opcode == c_OP_BNE);
          w_next        = S_FETCH;
        end
        S_IEXEC: begin
          w_aluSrcA = 1'b1;
          w_aluSrcB = 2'b10;
          w_aluOp   = (i_opcode == c_OP_ORI) ? c_ALU_OR : c_ALU_ADD;
          w_next    = S_IWB;
        end
        S_IWB: begin
          w_regWrite = 1'b1;
          w_next     = S_FETCH;
        end
        S_JUMP: begin
          w_pcWrite  = 1'b1;
          w_pcSource = 2'b10;
          w_next     = S_FETCH;
        end
        S_JR: begin
          w_pcWrite  = 1'b1;
          w_pcSource = 2'b11;
          w_next     = S_FETCH;
        end
        S_JAL: begin
          w_pcWrite  = 1'b1;
          w_pcSource = 2'b10;
          w_regWrite = 1'b1;
          w_regDst   = 2'b10;
          w_memToReg = 2'b10;
          w_next     = S_FETCH;
        end
`ifdef MCTRL_ILLEGAL_TRAP_EN
        S_TRAP:  w_next = S_TRAP;
`endif
        default: w_next = S_FETCH;
      endcase
    end
  end

`ifdef MCTRL_ILLEGAL_TRAP_EN
  logic r_illegal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_illegal <= 1'b0;
    else if (w_next == S_TRAP)
      r_illegal <= 1'b1;
  end

  assign o_illegalOp = r_illegal;
`else
  assign o_illegalOp = 1'b0;
`endif

  assign o_pcWrite     = w_pcWrite;
  assign o_pcWriteCond = w_pcWriteCond;
  assign o_branchNe    = w_branchNe;
  assign o_pcSource    = w_pcSource;
  assign o_iorD        = w_iorD;
  assign o_memRead     = w_memRead;
  assign o_memWrite    = w_memWrite;
  assign o_irWrite     = w_irWrite;
  assign o_regDst      = w_regDst;
  assign o_memToReg    = w_memToReg;
  assign o_regWrite    = w_regWrite;
  assign o_aluSrcA     = w_aluSrcA;
  assign o_aluSrcB     = w_aluSrcB;
  assign o_aluOp       = ALUOP_W'(w_aluOp);
  assign o_state       = r_state;
  assign o_retired     = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction stream against a per-instruction path/latency model.
`default_nettype none

module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode, funct;
  logic        memReady;
  logic        pcWrite, pcWriteCond, branchNe, iorD, memRead, memWrite, irWrite, regWrite, aluSrcA;
  logic [1:0]  pcSource, regDst, memToReg, aluSrcB;
  logic [2:0]  aluOp;
  logic [3:0]  state;
  logic [31:0] retired;
  logic        illegalOp;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_ret  = 0;
  int path[$];

  always #5 clk = ~clk;

  multicycle_control #(.ALUOP_W(3), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .i_opcode(opcode), .i_funct(funct), .i_memReady(memReady),
    .o_pcWrite(pcWrite), .o_pcWriteCond(pcWriteCond), .o_branchNe(branchNe),
    .o_pcSource(pcSource), .o_iorD(iorD), .o_memRead(memRead), .o_memWrite(memWrite),
    .o_irWrite(irWrite), .o_regDst(regDst), .o_memToReg(memToReg), .o_regWrite(regWrite),
    .o_aluSrcA(aluSrcA), .o_aluSrcB(aluSrcB), .o_aluOp(aluOp), .o_state(state),
    .o_retired(retired), .o_illegalOp(illegalOp)
  );

  logic [19:0] w_ctrl;
  assign w_ctrl = {pcWrite, pcWriteCond, branchNe, pcSource, iorD, memRead, memWrite, irWrite,
                   regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluOp};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Control word the spec table prescribes for a given state name.
  function automatic logic [19:0] exp_ctrl(input int s, input int op, input bit mr);
    logic pw, pwc, bne, iord, mrd, mwr, irw, rw, asa;
    logic [1:0] ps, rd, m2r, asb;
    logic [2:0] aop;
    {pw, pwc, bne, iord, mrd, mwr, irw, rw, asa} = '0;
    {ps, rd, m2r, asb} = '0;
    aop = 3'd0;
    case (s)
      0:  begin mrd = 1; asb = 2'b01; if (mr) begin irw = 1; pw = 1; end end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mrd = 1; iord = 1; end
      4:  begin rw = 1; m2r = 2'b01; end
      5:  begin mwr = 1; iord = 1; end
      6:  begin asa = 1; aop = 3'd2; end
      7:  begin rw = 1; rd = 2'b01; end
      8:  begin asa = 1; aop = 3'd1; pwc = 1; ps = 2'b01; bne = (op == 5); end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin asa = 1; asb = 2'b10; aop = (op == 13) ? 3'd3 : 3'd0; end
      11: rw = 1;
      12: begin pw = 1; ps = 2'b11; end
      13: begin pw = 1; ps = 2'b10; rw = 1; rd = 2'b10; m2r = 2'b10; end
      default: ;
    endcase
    return {pw, pwc, bne, ps, iord, mrd, mwr, irw, rd, m2r, rw, asa, asb, aop};
  endfunction

  // Zero-wait cycle counts as stated for each instruction class.
  function automatic int base_lat(input int op, input int fn);
    case (op)
      35:            return 5;
      43, 8, 13:     return 4;
      0:             return (fn == 8) ? 3 : 4;
      2, 3, 4, 5:    return 3;
      default:       return 2;
    endcase
  endfunction

  task automatic build_path(input int op, input int fn);
    path.delete();
    path.push_back(0);
    path.push_back(1);
    case (op)
      0:       if (fn == 8) path.push_back(12); else begin path.push_back(6); path.push_back(7); end
      35:      begin path.push_back(2); path.push_back(3); path.push_back(4); end
      43:      begin path.push_back(2); path.push_back(5); end
      4, 5:    path.push_back(8);
      8, 13:   begin path.push_back(10); path.push_back(11); end
      2:       path.push_back(9);
      3:       path.push_back(13);
      default: ;
    endcase
  endtask

  // Starts with the DUT in FETCH, mid-cycle; ends #1 after the edge that re-enters FETCH.
  task automatic run_instr(input int op, input int fn);
    int idx = 0, cycles = 0, waits = 0, es;
    bit mr;
    opcode = 6'(op);
    funct  = 6'(fn);
    build_path(op, fn);
    while (idx < path.size() && cycles < 200) begin
      mr = ($urandom_range(0, 3) != 0);
      memReady = mr;
      #1;
      es = path[idx];
      check($sformatf("state op%0d", op), 64'(state), 64'(es));
      check($sformatf("ctrl op%0d st%0d", op, es), 64'(w_ctrl), 64'(exp_ctrl(es, op, mr)));
      check("illegalOp", 64'(illegalOp), 64'd0);
      if ((es == 0 || es == 3 || es == 5) && !mr) waits++;
      else idx++;
      cycles++;
      @(posedge clk);
      #1;
    end
    check("timeout", 64'(idx), 64'(path.size()));
    check($sformatf("latency op%0d", op), 64'(cycles), 64'(base_lat(op, fn) + waits));
    exp_ret++;
    check("retired", 64'(retired), 64'(exp_ret));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " ctrl"}, 64'(w_ctrl), 64'd0);
    check({tag, " state"}, 64'(state), 64'd0);
    check({tag, " retired"}, 64'(retired), 64'd0);
    check({tag, " illegal"}, 64'(illegalOp), 64'd0);
  endtask

  initial begin
    int legal[9] = '{0, 2, 3, 4, 5, 8, 13, 35, 43};
    int op, fn, k;
    reset = 1'b1; memReady = 1'b1; opcode = 6'd0; funct = 6'd32;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_quiet("reset");
    end
    reset = 1'b0;
    #1;

    run_instr(0, 32);
    run_instr(5, 0);
    run_instr(4, 0);
    run_instr(3, 0);
    run_instr(0, 8);
    run_instr(35, 0);

    for (int n = 0; n < 80; n++) begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
      k = $urandom_range(0, 8);
`else
      k = $urandom_range(0, 9);
`endif
      if (k == 9) op = 14 + $urandom_range(0, 20);
      else op = legal[k];
      fn = (op == 0 && $urandom_range(0, 3) == 0) ? 8 : $urandom_range(0, 63);
      run_instr(op, fn);
    end

    // Abort a store while it waits on memory.
    opcode = 6'd43; funct = 6'd0; memReady = 1'b1;
    repeat (3) @(posedge clk);
    #1 memReady = 1'b0;
    #1;
    check("sw memWrite", 64'(memWrite), 64'd1);
    check("sw state", 64'(state), 64'd5);
    reset = 1'b1;
    #1;
    check_quiet("abort");
    @(negedge clk);
    reset = 1'b0;
    exp_ret = 0;
    #1;

`ifdef MCTRL_ILLEGAL_TRAP_EN
    opcode = 6'd63; memReady = 1'b1;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("trap state", 64'(state), 64'd14);
      check("trap flag", 64'(illegalOp), 64'd1);
      check("trap ctrl", 64'(w_ctrl), 64'd0);
      check("trap retired", 64'(retired), 64'(exp_ret));
      @(posedge clk);
    end
    #1 reset = 1'b1;
    #1;
    check_quiet("trap reset");
    @(negedge clk);
    reset = 1'b0;
    #1;
`endif
    run_instr(8, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
